// File: rtl/kw_credit_fifo.sv
// Credit-managed receive FIFO: absorbs a no-backpressure valid stream and presents
// it as show-ahead ready/valid, returning one credit pulse per popped entry.
module kw_credit_fifo #(
  parameter  int DATA_WIDTH = 8,
  parameter  int DEPTH      = 4,
  localparam int CW         = $clog2(DEPTH + 1)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  i_v,
  input  logic [DATA_WIDTH-1:0] i,
  output logic                  o_v,
  output logic [DATA_WIDTH-1:0] o,
  input  logic                  o_ready,
  output logic                  credit_o,
  output logic [CW-1:0]         count,
  output logic                  overflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wptr_q, wptr_d;
  logic [PW-1:0]         rptr_q, rptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  credit_q;
  logic                  overflow_q, overflow_d;
  logic                  full;
  logic                  push;
  logic                  pop;

  // Pointers wrap explicitly so non-power-of-2 depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    full       = (count_q == CW'(DEPTH));
    pop        = (count_q != '0) && o_ready;
    push       = i_v && (!full || pop);
    wptr_d     = push ? ptr_inc(wptr_q) : wptr_q;
    rptr_d     = pop  ? ptr_inc(rptr_q) : rptr_q;
    overflow_d = overflow_q || (i_v && !push);
    count_d    = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      credit_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      credit_q   <= pop;
      overflow_q <= overflow_d;
    end
  end

  // Storage is deliberately not reset; o is gated by o_v instead.
  always_ff @(posedge clock) begin
    if (push) mem_q[wptr_q] <= i;
  end

  assign o_v      = (count_q != '0);
  assign o        = o_v ? mem_q[rptr_q] : '0;
  assign credit_o = credit_q;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_kw_credit_fifo.sv
// Self-checking bench for kw_credit_fifo: DEPTH=4 and DEPTH=3 instances, each
// tracked every cycle by a reference model with a scoreboard queue.
module tb_kw_credit_fifo;

  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset_n;

  logic       iv4, rdy4, ov4, cr4, ovf4;
  logic [7:0] i4, o4;
  logic [2:0] cnt4;
  logic       iv3, rdy3, ov3, cr3, ovf3;
  logic [7:0] i3, o3;
  logic [1:0] cnt3;

  kw_credit_fifo #(.DATA_WIDTH(8), .DEPTH(4)) dut4 (
    .clock(clock), .reset_n(reset_n), .i_v(iv4), .i(i4), .o_v(ov4), .o(o4),
    .o_ready(rdy4), .credit_o(cr4), .count(cnt4), .overflow(ovf4));

  kw_credit_fifo #(.DATA_WIDTH(8), .DEPTH(3)) dut3 (
    .clock(clock), .reset_n(reset_n), .i_v(iv3), .i(i3), .o_v(ov3), .o(o3),
    .o_ready(rdy3), .credit_o(cr3), .count(cnt3), .overflow(ovf3));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [7:0] sbq0[$];
  logic [7:0] sbq1[$];
  int   mcnt[2];
  int   pops[2];
  int   creds[2];
  logic mcred[2];
  logic movf[2];

  task automatic mon(input int k, input int depth, input logic ov, input logic [7:0] od,
                     input logic [31:0] cnt, input logic cr, input logic ovf,
                     input logic iv, input logic [7:0] id, input logic rdy);
    string p;
    logic [7:0] head;
    bit pop, push;
    p = (k == 0) ? "d4" : "d3";
    if (!reset_n) begin
      mcnt[k] = 0; mcred[k] = 1'b0; movf[k] = 1'b0;
      if (k == 0) sbq0.delete(); else sbq1.delete();
      return;
    end
    head = 8'h00;
    if (mcnt[k] != 0) head = (k == 0) ? sbq0[0] : sbq1[0];
    chk({p, ".o_v"}, 32'(ov), 32'(mcnt[k] != 0));
    chk({p, ".o"}, 32'(od), 32'(head));
    chk({p, ".count"}, cnt, 32'(mcnt[k]));
    chk({p, ".credit_o"}, 32'(cr), 32'(mcred[k]));
    chk({p, ".overflow"}, 32'(ovf), 32'(movf[k]));
    pop  = (mcnt[k] != 0) && rdy;
    push = iv && ((mcnt[k] < depth) || pop);
    if (iv && !push) movf[k] = 1'b1;
    if (pop) begin
      pops[k]++;
      if (k == 0) void'(sbq0.pop_front()); else void'(sbq1.pop_front());
    end
    if (push) begin
      if (k == 0) sbq0.push_back(id); else sbq1.push_back(id);
    end
    mcnt[k]  = mcnt[k] + int'(push) - int'(pop);
    mcred[k] = pop;
    if (cr) creds[k]++;
  endtask

  always @(negedge clock) begin
    mon(0, 4, ov4, o4, 32'(cnt4), cr4, ovf4, iv4, i4, rdy4);
    mon(1, 3, ov3, o3, 32'(cnt3), cr3, ovf3, iv3, i3, rdy3);
  end

  task automatic step4(input logic iv, input logic [7:0] d, input logic rdy);
    @(posedge clock); #1;
    iv4 = iv; i4 = d; rdy4 = rdy;
  endtask

  task automatic fill4();
    step4(1'b1, 8'h11, 1'b0);
    step4(1'b1, 8'h22, 1'b0);
    step4(1'b1, 8'h33, 1'b0);
    step4(1'b1, 8'h44, 1'b0);
    step4(1'b0, 8'h00, 1'b0);
  endtask

  task automatic drain4(input int n);
    for (int j = 0; j < n; j++) step4(1'b0, 8'h00, 1'b1);
    step4(1'b0, 8'h00, 1'b0);
    step4(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    int p0, c0, credits, seq, sent;
    int pv[3];
    int pd[3];
    for (int k = 0; k < 2; k++) begin
      mcnt[k] = 0; pops[k] = 0; creds[k] = 0; mcred[k] = 1'b0; movf[k] = 1'b0;
    end
    reset_n = 1'b0;
    iv4 = 1'b0; i4 = 8'h00; rdy4 = 1'b0;
    iv3 = 1'b0; i3 = 8'h00; rdy3 = 1'b0;
    repeat (2) @(posedge clock);
    #3 reset_n = 1'b1;
    chk("reset.o_v", 32'(ov4), 32'd0);
    chk("reset.o", 32'(o4), 32'd0);
    chk("reset.count", 32'(cnt4), 32'd0);
    chk("reset.credit_o", 32'(cr4), 32'd0);
    chk("reset.overflow", 32'(ovf4), 32'd0);

    // fill then drain
    p0 = pops[0]; c0 = creds[0];
    fill4();
    chk("fill.count", 32'(cnt4), 32'd4);
    chk("fill.o", 32'(o4), 32'h11);
    drain4(4);
    chk("drain.count", 32'(cnt4), 32'd0);
    chk("drain.o", 32'(o4), 32'd0);
    chk("drain.pops", 32'(pops[0] - p0), 32'd4);
    chk("drain.credits", 32'(creds[0] - c0), 32'd4);

    // full with simultaneous push and pop
    fill4();
    step4(1'b1, 8'h55, 1'b1);
    step4(1'b0, 8'h00, 1'b0);
    chk("fullpp.count", 32'(cnt4), 32'd4);
    chk("fullpp.overflow", 32'(ovf4), 32'd0);
    chk("fullpp.o", 32'(o4), 32'h22);
    drain4(4);
    chk("fullpp.empty", 32'(cnt4), 32'd0);

    // overflow
    fill4();
    step4(1'b1, 8'h66, 1'b0);
    step4(1'b0, 8'h00, 1'b0);
    chk("ovf.overflow", 32'(ovf4), 32'd1);
    chk("ovf.count", 32'(cnt4), 32'd4);
    drain4(4);
    chk("ovf.sticky", 32'(ovf4), 32'd1);
    chk("ovf.empty", 32'(cnt4), 32'd0);

    // asynchronous reset mid-operation
    step4(1'b1, 8'hA1, 1'b0);
    step4(1'b1, 8'hA2, 1'b0);
    step4(1'b0, 8'h00, 1'b0);
    chk("rst.pre_count", 32'(cnt4), 32'd2);
    #2 reset_n = 1'b0;
    #1;
    chk("rst.o_v", 32'(ov4), 32'd0);
    chk("rst.count", 32'(cnt4), 32'd0);
    chk("rst.credit_o", 32'(cr4), 32'd0);
    chk("rst.overflow", 32'(ovf4), 32'd0);
    @(posedge clock); #3 reset_n = 1'b1;
    step4(1'b1, 8'h7A, 1'b0);
    step4(1'b0, 8'h00, 1'b1);
    chk("rst.next_o", 32'(o4), 32'h7A);
    step4(1'b0, 8'h00, 1'b0);
    step4(1'b0, 8'h00, 1'b0);
    chk("rst.drained", 32'(cnt4), 32'd0);

    // wrap-around on DEPTH=3 with a credit-respecting sender
    p0 = pops[1]; c0 = creds[1]; credits = 3; seq = 0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clock); #1;
      if (cr3) credits++;
      if (seq < 10 && credits > 0) begin
        iv3 = 1'b1; i3 = 8'(seq); seq++; credits--;
      end else iv3 = 1'b0;
      rdy3 = (c % 2 == 0);
      if (seq == 10 && (pops[1] - p0) == 10) break;
    end
    iv3 = 1'b0; rdy3 = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("wrap.pops", 32'(pops[1] - p0), 32'd10);
    chk("wrap.credits", 32'(creds[1] - c0), 32'd10);
    chk("wrap.overflow", 32'(ovf3), 32'd0);

    // credit-loop soak: 4 credits behind a 3-stage valid pipe
    p0 = pops[0]; credits = 4; sent = 0;
    for (int s = 0; s < 3; s++) begin pv[s] = 0; pd[s] = 0; end
    for (int c = 0; c < 10040; c++) begin
      @(posedge clock); #1;
      if (cr4) credits++;
      pv[2] = pv[1]; pd[2] = pd[1];
      pv[1] = pv[0]; pd[1] = pd[0];
      pv[0] = 0;
      if (c < 10000 && credits > 0) begin
        pv[0] = 1; pd[0] = sent; sent++; credits--;
      end
      iv4 = (pv[2] != 0); i4 = 8'(pd[2]);
      rdy4 = (c < 10000) ? ($urandom_range(0, 99) < 30) : 1'b1;
    end
    iv4 = 1'b0; rdy4 = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("soak.delivered", 32'(pops[0] - p0), 32'(sent));
    chk("soak.overflow", 32'(ovf4), 32'd0);
    chk("soak.count", 32'(cnt4), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
